// File: rtl/bypass_source_pipe_if.sv
// Bus between the decode/ALU datapath and the bypass source pipe.
// The datapath side uses the master modport, the pipe uses the slave modport.
// Optional macro BYPASS_STALL_COUNT_EN adds the stall_count observation output.
interface bypass_source_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              rf_valid;
   logic [REG_W-1:0]  rf_ra;
   logic [REG_W-1:0]  rf_rb;
   logic [REG_W-1:0]  rf_rc;
   logic [DATA_W-1:0] rf_pc;
   logic              rf_op_ld;
   logic              rf_op_br_or_jmp;
   logic              flush;
   logic [DATA_W-1:0] alu_y;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_rf;
   logic [REG_W-1:0]  rc_ex;
   logic [REG_W-1:0]  rc_mem;
   logic [REG_W-1:0]  rc_wb;
   logic              op_br_or_jmp_ex;
   logic              op_br_or_jmp_mem;
   logic [DATA_W-1:0] ex_y_bypass;
   logic [DATA_W-1:0] ex_pc_bypass;
   logic [DATA_W-1:0] mem_y_bypass;
   logic [DATA_W-1:0] mem_pc_bypass;
   logic [DATA_W-1:0] wb_bypass;
   logic              wb_we;
`ifdef BYPASS_STALL_COUNT_EN
   logic [31:0]       stall_count;
`endif

   modport master (
      output rf_valid, rf_ra, rf_rb, rf_rc, rf_pc, rf_op_ld, rf_op_br_or_jmp,
             flush, alu_y, mem_rdata,
      input  stall_rf, rc_ex, rc_mem, rc_wb, op_br_or_jmp_ex, op_br_or_jmp_mem,
             ex_y_bypass, ex_pc_bypass, mem_y_bypass, mem_pc_bypass,
             wb_bypass, wb_we
`ifdef BYPASS_STALL_COUNT_EN
      , input stall_count
`endif
   );

   modport slave (
      input  rf_valid, rf_ra, rf_rb, rf_rc, rf_pc, rf_op_ld, rf_op_br_or_jmp,
             flush, alu_y, mem_rdata,
      output stall_rf, rc_ex, rc_mem, rc_wb, op_br_or_jmp_ex, op_br_or_jmp_mem,
             ex_y_bypass, ex_pc_bypass, mem_y_bypass, mem_pc_bypass,
             wb_bypass, wb_we
`ifdef BYPASS_STALL_COUNT_EN
      , output stall_count
`endif
   );
endinterface

// File: rtl/bypass_source_pipe.sv
// Producer side of the operand bypass network: EX, MEM and WB destination
// tags and results, every bypass value the RF-stage operand muxes consume,
// and load-use hazard detection that stalls RF and bubbles EX.
// Empty or annulled stages carry the zero-register tag so no reader matches.
// Optional macro BYPASS_STALL_COUNT_EN adds a free-running stall cycle counter.
module bypass_source_pipe #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int ZR_ADDR = 31
) (
   input logic                 clk,
   input logic                 rst,
   bypass_source_pipe_if.slave bus
);
   localparam logic [REG_W-1:0] ZR = REG_W'(ZR_ADDR);

   logic [REG_W-1:0]  rc_ex;
   logic [DATA_W-1:0] pc_ex;
   logic              ld_ex;
   logic              bj_ex;

   logic [REG_W-1:0]  rc_mem;
   logic [DATA_W-1:0] pc_mem;
   logic [DATA_W-1:0] y_mem;
   logic              ld_mem;
   logic              bj_mem;

   logic [REG_W-1:0]  rc_wb;
   logic [DATA_W-1:0] val_wb;

   logic              hit_ex;
   logic              hit_mem;
   logic              stall;
   logic              bubble;
   logic [DATA_W-1:0] wb_sel;

   // Load-use detection: a load in EX or MEM has no usable value yet, so a matching reader waits
   always_comb begin
      hit_ex  = 1'b0;
      hit_mem = 1'b0;
      if (ld_ex && (rc_ex != ZR) && ((rc_ex == bus.rf_ra) || (rc_ex == bus.rf_rb))) begin
         hit_ex = 1'b1;
      end
      if (ld_mem && (rc_mem != ZR) && ((rc_mem == bus.rf_ra) || (rc_mem == bus.rf_rb))) begin
         hit_mem = 1'b1;
      end
      stall  = bus.rf_valid && (hit_ex || hit_mem);
      bubble = stall || bus.flush || !bus.rf_valid;
   end

   // WB value select: load data beats link PC, which beats the ALU result
   always_comb begin
      wb_sel = y_mem;
      if (ld_mem) begin
         wb_sel = bus.mem_rdata;
      end else if (bj_mem) begin
         wb_sel = pc_mem;
      end
   end

   // EX register: takes the RF instruction or a bubble; pc is left alone on a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         rc_ex <= ZR;
         pc_ex <= '0;
         ld_ex <= 1'b0;
         bj_ex <= 1'b0;
      end else if (bubble) begin
         rc_ex <= ZR;
         ld_ex <= 1'b0;
         bj_ex <= 1'b0;
      end else begin
         rc_ex <= bus.rf_rc;
         pc_ex <= bus.rf_pc;
         ld_ex <= bus.rf_op_ld;
         bj_ex <= bus.rf_op_br_or_jmp;
      end
   end

   // MEM register: never stalls, captures the EX stage and its ALU result
   always_ff @(posedge clk) begin
      if (rst) begin
         rc_mem <= ZR;
         pc_mem <= '0;
         y_mem  <= '0;
         ld_mem <= 1'b0;
         bj_mem <= 1'b0;
      end else begin
         rc_mem <= rc_ex;
         pc_mem <= pc_ex;
         y_mem  <= bus.alu_y;
         ld_mem <= ld_ex;
         bj_mem <= bj_ex;
      end
   end

   // WB register: never stalls, captures the MEM tag and the selected write value
   always_ff @(posedge clk) begin
      if (rst) begin
         rc_wb  <= ZR;
         val_wb <= '0;
      end else begin
         rc_wb  <= rc_mem;
         val_wb <= wb_sel;
      end
   end

`ifdef BYPASS_STALL_COUNT_EN
   logic [31:0] stall_count_q;

   // Stall cycle counter, wraps naturally at 32 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count_q <= '0;
      end else if (stall) begin
         stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign bus.stall_count = stall_count_q;
`endif

   assign bus.stall_rf         = stall;
   assign bus.rc_ex            = rc_ex;
   assign bus.rc_mem           = rc_mem;
   assign bus.rc_wb            = rc_wb;
   assign bus.op_br_or_jmp_ex  = bj_ex;
   assign bus.op_br_or_jmp_mem = bj_mem;
   assign bus.ex_y_bypass      = bus.alu_y;
   assign bus.ex_pc_bypass     = pc_ex;
   assign bus.mem_y_bypass     = y_mem;
   assign bus.mem_pc_bypass    = pc_mem;
   assign bus.wb_bypass        = val_wb;
   assign bus.wb_we            = (rc_wb != ZR);
endmodule

// File: tb/tb_bypass_source_pipe.sv
// Directed, table-driven bench for bypass_source_pipe.
// Each table row gives one cycle of inputs, the expected stall_rf before the
// edge, and the expected registered outputs after the edge.
module tb_bypass_source_pipe;
   logic clk;
   logic rst;

   bypass_source_pipe_if #(.DATA_W(32), .REG_W(5)) bus ();

   bypass_source_pipe #(.DATA_W(32), .REG_W(5), .ZR_ADDR(31)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic        rst;
      logic        valid;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rc;
      logic [31:0] pc;
      logic        ld;
      logic        bj;
      logic        flush;
      logic [31:0] alu_y;
      logic [31:0] rdata;
      logic        e_stall;
      logic [4:0]  e_ex;
      logic [4:0]  e_mem;
      logic [4:0]  e_wb;
      logic        e_we;
      logic [31:0] e_wbv;
   } vec_t;

   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time expired");
      $fatal(1, "[TB] timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic v, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [4:0] rc, input logic [31:0] pc, input logic ld, input logic bj,
                      input logic fl, input logic [31:0] y, input logic [31:0] rd,
                      input logic es, input logic [4:0] eex, input logic [4:0] emem,
                      input logic [4:0] ewb, input logic ewe, input logic [31:0] ewbv);
      vec_t t;
      t.rst = r; t.valid = v; t.ra = ra; t.rb = rb; t.rc = rc; t.pc = pc;
      t.ld = ld; t.bj = bj; t.flush = fl; t.alu_y = y; t.rdata = rd;
      t.e_stall = es; t.e_ex = eex; t.e_mem = emem; t.e_wb = ewb;
      t.e_we = ewe; t.e_wbv = ewbv;
      vecs.push_back(t);
   endtask

   task automatic apply_stimulus(input vec_t t);
      rst                 = t.rst;
      bus.rf_valid        = t.valid;
      bus.rf_ra           = t.ra;
      bus.rf_rb           = t.rb;
      bus.rf_rc           = t.rc;
      bus.rf_pc           = t.pc;
      bus.rf_op_ld        = t.ld;
      bus.rf_op_br_or_jmp = t.bj;
      bus.flush           = t.flush;
      bus.alu_y           = t.alu_y;
      bus.mem_rdata       = t.rdata;
   endtask

   task automatic check_output(input vec_t t, input int idx);
      string s;
      s = $sformatf("row%0d", idx);
      check({s, " rc_ex"},     32'(bus.rc_ex),  32'(t.e_ex));
      check({s, " rc_mem"},    32'(bus.rc_mem), 32'(t.e_mem));
      check({s, " rc_wb"},     32'(bus.rc_wb),  32'(t.e_wb));
      check({s, " wb_we"},     32'(bus.wb_we),  32'(t.e_we));
      check({s, " wb_bypass"}, bus.wb_bypass,   t.e_wbv);
   endtask

   task automatic idle();
      bus.rf_valid = 1'b0; bus.rf_ra = 5'd31; bus.rf_rb = 5'd31; bus.rf_rc = 5'd31;
      bus.rf_pc = 32'h0; bus.rf_op_ld = 1'b0; bus.rf_op_br_or_jmp = 1'b0;
      bus.flush = 1'b0; bus.alu_y = 32'h0; bus.mem_rdata = 32'h0;
   endtask

   initial begin
      //   rst v  ra  rb  rc  pc        ld bj fl alu_y       rdata        st ex  mem wb  we wbv
      // ALU chain
      add(0, 1, 1,  31, 3,  32'h100, 0, 0, 0, 32'h0,      32'h0,       0, 3,  31, 31, 0, 32'h0);
      add(0, 1, 3,  31, 4,  32'h104, 0, 0, 0, 32'h10,     32'h0,       0, 4,  3,  31, 0, 32'h0);
      add(0, 0, 31, 31, 31, 32'h0,   0, 0, 0, 32'h20,     32'h0,       0, 31, 4,  3,  1, 32'h10);
      add(0, 0, 31, 31, 31, 32'h0,   0, 0, 0, 32'h0,      32'h0,       0, 31, 31, 4,  1, 32'h20);
      // load-use, reader on rb
      add(0, 1, 2,  31, 5,  32'h200, 1, 0, 0, 32'h0,      32'h0,       0, 5,  31, 31, 0, 32'h0);
      add(0, 1, 1,  5,  6,  32'h204, 0, 0, 0, 32'h300,    32'h0,       1, 31, 5,  31, 0, 32'h0);
      add(0, 1, 1,  5,  6,  32'h204, 0, 0, 0, 32'h0,      32'hDEAD,    1, 31, 31, 5,  1, 32'hDEAD);
      add(0, 1, 1,  5,  6,  32'h204, 0, 0, 0, 32'h0,      32'h0,       0, 6,  31, 31, 0, 32'h0);
      // branch link
      add(0, 1, 1,  2,  28, 32'h104, 0, 1, 0, 32'h55,     32'h0,       0, 28, 6,  31, 0, 32'h0);
      add(0, 0, 31, 31, 31, 32'h0,   0, 0, 0, 32'h77,     32'h0,       0, 31, 28, 6,  1, 32'h55);
      add(0, 0, 31, 31, 31, 32'h0,   0, 0, 0, 32'h0,      32'h0,       0, 31, 31, 28, 1, 32'h104);
      // flush of a valid instruction
      add(0, 1, 1,  2,  7,  32'h300, 0, 0, 1, 32'h0,      32'h0,       0, 31, 31, 31, 0, 32'h0);
      add(0, 0, 31, 31, 31, 32'h0,   0, 0, 0, 32'h0,      32'h0,       0, 31, 31, 31, 0, 32'h0);
      // load to R31 never stalls a R31 reader
      add(0, 1, 1,  31, 31, 32'h400, 1, 0, 0, 32'h0,      32'h0,       0, 31, 31, 31, 0, 32'h0);
      add(0, 1, 31, 31, 8,  32'h404, 0, 0, 0, 32'h9,      32'h0,       0, 8,  31, 31, 0, 32'h0);
      add(0, 0, 31, 31, 31, 32'h0,   0, 0, 0, 32'h11,     32'hBEEF,    0, 31, 8,  31, 0, 32'hBEEF);
      add(0, 0, 31, 31, 31, 32'h0,   0, 0, 0, 32'h0,      32'h0,       0, 31, 31, 8,  1, 32'h11);
      // flush together with stall
      add(0, 1, 1,  31, 9,  32'h500, 1, 0, 0, 32'h0,      32'h0,       0, 9,  31, 31, 0, 32'h0);
      add(0, 1, 9,  31, 10, 32'h504, 0, 0, 1, 32'h0,      32'h0,       1, 31, 9,  31, 0, 32'h0);
      add(0, 1, 9,  31, 10, 32'h504, 0, 0, 0, 32'h0,      32'hCAFE,    1, 31, 31, 9,  1, 32'hCAFE);
      add(0, 1, 9,  31, 10, 32'h504, 0, 0, 0, 32'h0,      32'h0,       0, 10, 31, 31, 0, 32'h0);
      // back-to-back loads to the same Rc
      add(0, 1, 0,  31, 12, 32'h600, 1, 0, 0, 32'h42,     32'h0,       0, 12, 10, 31, 0, 32'h0);
      add(0, 1, 1,  31, 12, 32'h604, 1, 0, 0, 32'h0,      32'h0,       0, 12, 12, 10, 1, 32'h42);
      add(0, 1, 1,  12, 13, 32'h608, 0, 0, 0, 32'h0,      32'hA1,      1, 31, 12, 12, 1, 32'hA1);
      add(0, 1, 1,  12, 13, 32'h608, 0, 0, 0, 32'h0,      32'hA2,      1, 31, 31, 12, 1, 32'hA2);
      add(0, 1, 1,  12, 13, 32'h608, 0, 0, 0, 32'h0,      32'h0,       0, 13, 31, 31, 0, 32'h0);
      // reset mid-operation
      add(0, 1, 1,  2,  14, 32'h700, 0, 0, 0, 32'h33,     32'h0,       0, 14, 13, 31, 0, 32'h0);
      add(1, 1, 1,  2,  15, 32'h704, 0, 0, 0, 32'h44,     32'h0,       0, 31, 31, 31, 0, 32'h0);
      add(0, 0, 31, 31, 31, 32'h0,   0, 0, 0, 32'h0,      32'h0,       0, 31, 31, 31, 0, 32'h0);

      // Reset held for two cycles
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset rc_ex",     32'(bus.rc_ex),    32'd31);
      check("reset rc_mem",    32'(bus.rc_mem),   32'd31);
      check("reset rc_wb",     32'(bus.rc_wb),    32'd31);
      check("reset wb_we",     32'(bus.wb_we),    32'd0);
      check("reset stall_rf",  32'(bus.stall_rf), 32'd0);
      check("reset wb_bypass", bus.wb_bypass,     32'h0);
`ifdef BYPASS_STALL_COUNT_EN
      check("reset stall_count", bus.stall_count, 32'd0);
`endif

      // Table-driven cycles
      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         #1;
         check($sformatf("row%0d stall_rf", i), 32'(bus.stall_rf), 32'(vecs[i].e_stall));
         @(negedge clk);
         check_output(vecs[i], i);
`ifdef BYPASS_STALL_COUNT_EN
         if (i == 6) check("stall_count after load-use", bus.stall_count, 32'd2);
`endif
      end
`ifdef BYPASS_STALL_COUNT_EN
      check("stall_count after reset", bus.stall_count, 32'd0);
`endif

      // Hand sequence: EX/MEM bypass values and branch flags
      idle();
      bus.rf_valid = 1'b1; bus.rf_ra = 5'd1; bus.rf_rc = 5'd3; bus.rf_pc = 32'h100;
      @(negedge clk);
      check("seq rc_ex",        32'(bus.rc_ex),           32'd3);
      check("seq ex_pc_bypass", bus.ex_pc_bypass,         32'h100);
      check("seq br_ex clear",  32'(bus.op_br_or_jmp_ex), 32'd0);
      bus.rf_ra = 5'd3; bus.rf_rc = 5'd4; bus.rf_pc = 32'h104; bus.alu_y = 32'h10;
      #1;
      check("seq ex_y_bypass",  bus.ex_y_bypass,          32'h10);
      check("seq stall alu",    32'(bus.stall_rf),        32'd0);
      @(negedge clk);
      check("seq rc_mem",       32'(bus.rc_mem),          32'd3);
      check("seq mem_y_bypass", bus.mem_y_bypass,         32'h10);
      bus.rf_ra = 5'd1; bus.rf_rc = 5'd28; bus.rf_pc = 32'h104; bus.rf_op_br_or_jmp = 1'b1;
      bus.alu_y = 32'h20;
      @(negedge clk);
      check("seq br_ex",        32'(bus.op_br_or_jmp_ex), 32'd1);
      check("seq wb 0x10",      bus.wb_bypass,            32'h10);
      idle();
      bus.alu_y = 32'h99;
      @(negedge clk);
      check("seq br_mem",       32'(bus.op_br_or_jmp_mem), 32'd1);
      check("seq mem_pc_bypass", bus.mem_pc_bypass,        32'h104);
      check("seq mem_y_bypass2", bus.mem_y_bypass,         32'h99);
      bus.alu_y = 32'h0;
      @(negedge clk);
      check("seq link rc_wb",   32'(bus.rc_wb),           32'd28);
      check("seq link wb",      bus.wb_bypass,            32'h104);
      check("seq link we",      32'(bus.wb_we),           32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
